// File: rtl/button_reader.sv
// button_reader: debounced push-button channels feeding a press/release event FIFO
// with a press counter and sticky overflow flag.
module button_reader #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic [N_BUTTONS-1:0]         BTN_N,
    output logic [N_BUTTONS-1:0]         STATE,
    output logic                         EVT_VALID,
    input  logic                         EVT_READY,
    output logic [$clog2(N_BUTTONS):0]   EVT_DATA,
    output logic [7:0]                   PRESS_COUNT,
    output logic                         OVERFLOW
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int IW = $clog2(N_BUTTONS);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {STABLE, CHANGING} ch_t;

    ch_t            st  [N_BUTTONS];
    logic [CW-1:0]  cnt [N_BUTTONS];
    logic [IW:0]    mem [FIFO_DEPTH];
    logic [N_BUTTONS-1:0] s1, s2, smp, tog, pend, lvl, clr;
    logic [7:0]     rises;
    logic [IW-1:0]  sel;
    logic [AW:0]    wp, rp;
    logic           any, full, pop, push, drop;

    always_comb begin
        smp   = ~s2;
        tog   = '0;
        rises = '0;
        any   = 1'b0;
        sel   = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            tog[i] = st[i] == CHANGING && smp[i] != STATE[i] && cnt[i] == CW'(DEBOUNCE_CYCLES - 1);
            rises  = rises + 8'(tog[i] & ~STATE[i]);
        end
        // Lowest index wins: scan downward so the last hit is the smallest.
        for (int i = N_BUTTONS - 1; i >= 0; i--)
            if (pend[i]) begin
                any = 1'b1;
                sel = IW'(i);
            end
        clr       = any ? N_BUTTONS'(1) << sel : '0;
        drop      = |(tog & pend & ~clr);
        full      = (wp ^ rp) == {1'b1, {AW{1'b0}}};
        EVT_VALID = wp != rp;
        EVT_DATA  = mem[rp[AW-1:0]];
        pop       = EVT_VALID & EVT_READY;
        push      = any & (~full | pop);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1          <= '1;
            s2          <= '1;
            STATE       <= '0;
            pend        <= '0;
            lvl         <= '0;
            PRESS_COUNT <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                st[i]  <= STABLE;
                cnt[i] <= '0;
            end
        end else begin
            s1          <= BTN_N;
            s2          <= s1;
            PRESS_COUNT <= PRESS_COUNT + rises;
            pend        <= tog | (pend & ~clr);
            for (int i = 0; i < N_BUTTONS; i++) begin
                if (tog[i])
                    lvl[i] <= smp[i];
                case (st[i])
                    STABLE: begin
                        st[i]  <= smp[i] != STATE[i] ? CHANGING : STABLE;
                        cnt[i] <= smp[i] != STATE[i] ? CW'(1) : '0;
                    end
                    default: begin
                        if (smp[i] == STATE[i] || tog[i]) begin
                            st[i]  <= STABLE;
                            cnt[i] <= '0;
                        end else
                            cnt[i] <= cnt[i] + CW'(1);
                        if (tog[i])
                            STATE[i] <= ~STATE[i];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wp       <= '0;
            rp       <= '0;
            OVERFLOW <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wp[AW-1:0]] <= {lvl[sel], sel};
                wp              <= wp + 1'b1;
            end
            if (pop)
                rp <= rp + 1'b1;
            OVERFLOW <= OVERFLOW | drop | (any & ~push);
        end
    end
endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: directed checks of debounce timing, glitch rejection,
// event ordering, overflow and asynchronous reset.
module tb_button_reader;
    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] BTN_N;
    logic [3:0] STATE;
    logic       EVT_VALID;
    logic       EVT_READY;
    logic [2:0] EVT_DATA;
    logic [7:0] PRESS_COUNT;
    logic       OVERFLOW;
    int         errors = 0;
    int         checks = 0;

    button_reader #(.N_BUTTONS(4), .DEBOUNCE_CYCLES(8), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .BTN_N(BTN_N), .STATE(STATE),
        .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_DATA(EVT_DATA),
        .PRESS_COUNT(PRESS_COUNT), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RESET_N   = 1'b0;
        BTN_N     = 4'b1111;
        EVT_READY = 1'b0;
        step(2);
        chk("rst_state", 32'(STATE), 0);
        chk("rst_valid", 32'(EVT_VALID), 0);
        chk("rst_data", 32'(EVT_DATA), 0);
        chk("rst_count", 32'(PRESS_COUNT), 0);
        chk("rst_ovf", 32'(OVERFLOW), 0);
        RESET_N = 1'b1;
        step(2);

        // single press on channel 2: exact 10-edge latency, event one cycle later
        BTN_N = 4'b1011;
        step(9);
        chk("p2_early", 32'(STATE), 0);
        step(1);
        chk("p2_state", 32'(STATE), 4'b0100);
        chk("p2_count", 32'(PRESS_COUNT), 1);
        chk("p2_novalid", 32'(EVT_VALID), 0);
        step(1);
        chk("p2_valid", 32'(EVT_VALID), 1);
        chk("p2_data", 32'(EVT_DATA), 3'b110);
        EVT_READY = 1'b1;
        step(1);
        chk("p2_popped", 32'(EVT_VALID), 0);
        EVT_READY = 1'b0;
        BTN_N = 4'b1111;
        step(10);
        chk("r2_state", 32'(STATE), 0);
        step(1);
        chk("r2_valid", 32'(EVT_VALID), 1);
        chk("r2_data", 32'(EVT_DATA), 3'b010);
        chk("r2_count", 32'(PRESS_COUNT), 1);
        EVT_READY = 1'b1;
        step(1);
        EVT_READY = 1'b0;

        // 5-cycle glitch on channel 0 is rejected
        BTN_N = 4'b1110;
        step(5);
        BTN_N = 4'b1111;
        step(20);
        chk("gl_state", 32'(STATE), 0);
        chk("gl_valid", 32'(EVT_VALID), 0);
        chk("gl_count", 32'(PRESS_COUNT), 1);

        // all four pressed together, drained in index order
        EVT_READY = 1'b1;
        BTN_N = 4'b0000;
        step(10);
        chk("all_state", 32'(STATE), 4'b1111);
        chk("all_count", 32'(PRESS_COUNT), 5);
        step(1);
        chk("all_e0", 32'({EVT_VALID, EVT_DATA}), 4'b1100);
        step(1);
        chk("all_e1", 32'({EVT_VALID, EVT_DATA}), 4'b1101);
        step(1);
        chk("all_e2", 32'({EVT_VALID, EVT_DATA}), 4'b1110);
        step(1);
        chk("all_e3", 32'({EVT_VALID, EVT_DATA}), 4'b1111);
        step(1);
        chk("all_empty", 32'(EVT_VALID), 0);
        BTN_N = 4'b1111;
        step(20);
        chk("allr_state", 32'(STATE), 0);
        chk("allr_empty", 32'(EVT_VALID), 0);
        chk("allr_ovf", 32'(OVERFLOW), 0);

        // six events into a four-deep queue with the consumer stalled
        EVT_READY = 1'b0;
        BTN_N = 4'b1000;
        step(20);
        chk("ov_state", 32'(STATE), 4'b0111);
        chk("ov_count", 32'(PRESS_COUNT), 8);
        chk("ov_pre_ovf", 32'(OVERFLOW), 0);
        chk("ov_pre_head", 32'(EVT_DATA), 3'b100);
        BTN_N = 4'b1111;
        step(15);
        chk("ov_rstate", 32'(STATE), 0);
        chk("ov_ovf", 32'(OVERFLOW), 1);
        chk("ov_head", 32'({EVT_VALID, EVT_DATA}), 4'b1100);
        EVT_READY = 1'b1;
        step(1);
        chk("ov_q1", 32'({EVT_VALID, EVT_DATA}), 4'b1101);
        step(1);
        chk("ov_q2", 32'({EVT_VALID, EVT_DATA}), 4'b1110);
        step(1);
        chk("ov_q3", 32'({EVT_VALID, EVT_DATA}), 4'b1000);
        step(1);
        chk("ov_empty", 32'(EVT_VALID), 0);
        chk("ov_sticky", 32'(OVERFLOW), 1);

        // reset with two events queued and channel 1 mid-debounce
        EVT_READY = 1'b0;
        BTN_N = 4'b0110;
        step(12);
        chk("mr_valid", 32'(EVT_VALID), 1);
        chk("mr_count", 32'(PRESS_COUNT), 10);
        BTN_N = 4'b0100;
        step(5);
        RESET_N = 1'b0;
        #1;
        chk("mr_rvalid", 32'(EVT_VALID), 0);
        chk("mr_rstate", 32'(STATE), 0);
        chk("mr_rcount", 32'(PRESS_COUNT), 0);
        chk("mr_rovf", 32'(OVERFLOW), 0);
        BTN_N = 4'b1111;
        step(2);
        RESET_N = 1'b1;
        step(30);
        chk("mr_after_valid", 32'(EVT_VALID), 0);
        chk("mr_after_state", 32'(STATE), 0);
        chk("mr_after_count", 32'(PRESS_COUNT), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
